// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the 4-stage IF/ID/EXE/WB interlock controller.
//   DEF_ASIZE : default register-address width (the legacy `ASIZE value)
//   ZERO_REG  : index of the hard-wired zero register
//   sb_slot_t : one scoreboard slot (a producer's destination register)
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int DEF_ASIZE = 5;
  localparam int ZERO_REG  = 0;

  typedef struct packed {
    logic                 valid;
    logic [DEF_ASIZE-1:0] addr;
  } sb_slot_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Compares one ID source operand against both scoreboard slots.
// Ports:
//   raddr      in  ASIZE  source register of the ID instruction
//   ex_v/ex_a  in         EXE slot valid / destination
//   wb_v/wb_a  in         WB slot valid / destination
//   hit        out 1      operand depends on a pending producer
// With WB_BYPASS the register file forwards the WB write on the same cycle,
// so only the EXE slot can block. With ZERO_REG_RO a write to register 0 is
// discarded, so it can never be a producer.
// -----------------------------------------------------------------------------
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ASIZE       = DEF_ASIZE,
  parameter bit WB_BYPASS   = 1'b0,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic [ASIZE-1:0] raddr,
  input  logic             ex_v,
  input  logic [ASIZE-1:0] ex_a,
  input  logic             wb_v,
  input  logic [ASIZE-1:0] wb_a,
  output logic             hit
);

  function automatic logic slot_match(input logic [ASIZE-1:0] r,
                                      input logic [ASIZE-1:0] a,
                                      input logic             v);
    return v && (r == a) && !(ZERO_REG_RO && (a == ASIZE'(ZERO_REG)));
  endfunction

  always_comb begin
    hit = slot_match(raddr, ex_a, ex_v) ||
          (!WB_BYPASS && slot_match(raddr, wb_a, wb_v));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// RAW interlock for the IF/ID/EXE/WB register-file pipeline. A shadow
// scoreboard mirrors the destination registers held in ID/EXE and EXE/WB;
// an ID instruction reading one of them stalls PC and IF/ID while a bubble
// is pushed into ID/EXE, until the producer has written back.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid                 ID holds a real instruction
//   id_raddr1/id_raddr2      rs / rt fields
//   id_use_rs2               rt is a source operand
//   id_wen/id_waddr          ID instruction write enable / destination
//   cnt_clr                  synchronous clear of stall_cnt (wins over +1)
//   stall, bubble            hold PC+IF/ID, zero ID/EXE wen (combinational)
//   ex_busy, wb_busy         scoreboard slot valid flags
//   stall_cnt                saturating count of stall cycles
// Slots drain in at most two edges, so re-evaluating every cycle is enough;
// no stall-length state is kept.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ASIZE       = DEF_ASIZE,
  parameter bit WB_BYPASS   = 1'b0,
  parameter bit ZERO_REG_RO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_raddr1,
  input  logic [ASIZE-1:0] id_raddr2,
  input  logic             id_use_rs2,
  input  logic             id_wen,
  input  logic [ASIZE-1:0] id_waddr,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             bubble,
  output logic             ex_busy,
  output logic             wb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_v;
  logic [ASIZE-1:0] ex_a;
  logic             wb_v;
  logic [ASIZE-1:0] wb_a;
  logic             hit1;
  logic             hit2;

  hazard_cmp #(
    .ASIZE      (ASIZE),
    .WB_BYPASS  (WB_BYPASS),
    .ZERO_REG_RO(ZERO_REG_RO)
  ) u_cmp_rs1 (
    .raddr(id_raddr1),
    .ex_v (ex_v),
    .ex_a (ex_a),
    .wb_v (wb_v),
    .wb_a (wb_a),
    .hit  (hit1)
  );

  hazard_cmp #(
    .ASIZE      (ASIZE),
    .WB_BYPASS  (WB_BYPASS),
    .ZERO_REG_RO(ZERO_REG_RO)
  ) u_cmp_rs2 (
    .raddr(id_raddr2),
    .ex_v (ex_v),
    .ex_a (ex_a),
    .wb_v (wb_v),
    .wb_a (wb_a),
    .hit  (hit2)
  );

  // Any combination of rs1/rs2 and EXE/WB matches is a single stall cycle.
  always_comb begin
    stall   = id_valid && (hit1 || (id_use_rs2 && hit2));
    bubble  = stall;
    ex_busy = ex_v;
    wb_busy = wb_v;
  end

  // Scoreboard shifts every edge; a stalled ID instruction is replaced by an
  // invalid entry so it is compared again next cycle rather than recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v <= 1'b0;
      ex_a <= '0;
      wb_v <= 1'b0;
      wb_a <= '0;
    end else begin
      wb_v <= ex_v;
      wb_a <= ex_a;
      if (stall) begin
        ex_v <= 1'b0;
      end else begin
        ex_v <= id_valid && id_wen;
        ex_a <= id_waddr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench. Four controllers share one ID stream:
//   dut     : defaults (no bypass, r0 read-only, 16-bit counter)
//   dut_b   : WB_BYPASS=1
//   dut_z   : ZERO_REG_RO=0
//   dut_c   : CNT_W=4, so saturation is reached in a few dozen cycles
// Inputs change 1ns after the rising edge; outputs are sampled before the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_raddr1 = '0;
  logic [4:0] id_raddr2 = '0;
  logic       id_use_rs2 = 1'b0;
  logic       id_wen = 1'b0;
  logic [4:0] id_waddr = '0;
  logic       cnt_clr = 1'b0;

  logic        stall_d, bubble_d, exb_d, wbb_d;
  logic [15:0] cnt_d;
  logic        stall_b, bubble_b, exb_b, wbb_b;
  logic [15:0] cnt_b;
  logic        stall_z, bubble_z, exb_z, wbb_z;
  logic [15:0] cnt_z;
  logic        stall_c, bubble_c, exb_c, wbb_c;
  logic [3:0]  cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1),
    .id_raddr2(id_raddr2), .id_use_rs2(id_use_rs2), .id_wen(id_wen),
    .id_waddr(id_waddr), .cnt_clr(cnt_clr), .stall(stall_d), .bubble(bubble_d),
    .ex_busy(exb_d), .wb_busy(wbb_d), .stall_cnt(cnt_d)
  );

  pipe_hazard_ctrl #(.WB_BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1),
    .id_raddr2(id_raddr2), .id_use_rs2(id_use_rs2), .id_wen(id_wen),
    .id_waddr(id_waddr), .cnt_clr(cnt_clr), .stall(stall_b), .bubble(bubble_b),
    .ex_busy(exb_b), .wb_busy(wbb_b), .stall_cnt(cnt_b)
  );

  pipe_hazard_ctrl #(.ZERO_REG_RO(1'b0)) dut_z (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1),
    .id_raddr2(id_raddr2), .id_use_rs2(id_use_rs2), .id_wen(id_wen),
    .id_waddr(id_waddr), .cnt_clr(cnt_clr), .stall(stall_z), .bubble(bubble_z),
    .ex_busy(exb_z), .wb_busy(wbb_z), .stall_cnt(cnt_z)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1),
    .id_raddr2(id_raddr2), .id_use_rs2(id_use_rs2), .id_wen(id_wen),
    .id_waddr(id_waddr), .cnt_clr(cnt_clr), .stall(stall_c), .bubble(bubble_c),
    .ex_busy(exb_c), .wb_busy(wbb_c), .stall_cnt(cnt_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                          input logic u2, input logic w, input logic [4:0] wa);
    id_valid   = v;
    id_raddr1  = a1;
    id_raddr2  = a2;
    id_use_rs2 = u2;
    id_wen     = w;
    id_waddr   = wa;
  endtask

  task automatic idle(input int n);
    id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counters();
    idle(0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // Producer of r7 followed by a non-writing reader of r7: two stall cycles
  // on the default configuration, leaving both slots empty afterwards.
  task automatic stall_pair();
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd7);
    tick();
    id_drive(1'b1, 5'd7, 5'd22, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    // ---- reset ----
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", {31'd0, stall_d}, 32'd0);
    check_eq("rst_bubble", {31'd0, bubble_d}, 32'd0);
    check_eq("rst_ex_busy", {31'd0, exb_d}, 32'd0);
    check_eq("rst_wb_busy", {31'd0, wbb_d}, 32'd0);
    check_eq("rst_cnt", {16'd0, cnt_d}, 32'd0);
    rst = 1'b1;
    tick();

    // ---- 1: independent writers r1, r2, r3 ----
    id_drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd1);
    #1 check_eq("t1_w1_stall", {31'd0, stall_d}, 32'd0);
    tick();
    check_eq("t1_w1_ex_busy", {31'd0, exb_d}, 32'd1);
    check_eq("t1_w1_wb_busy", {31'd0, wbb_d}, 32'd0);
    id_drive(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd2);
    #1 check_eq("t1_w2_stall", {31'd0, stall_d}, 32'd0);
    tick();
    check_eq("t1_w2_ex_busy", {31'd0, exb_d}, 32'd1);
    check_eq("t1_w2_wb_busy", {31'd0, wbb_d}, 32'd1);
    id_drive(1'b1, 5'd14, 5'd15, 1'b1, 1'b1, 5'd3);
    #1 check_eq("t1_w3_stall", {31'd0, stall_d}, 32'd0);
    tick();
    check_eq("t1_cnt", {16'd0, cnt_d}, 32'd0);
    idle(1);
    check_eq("t1_drain1_ex_busy", {31'd0, exb_d}, 32'd0);
    check_eq("t1_drain1_wb_busy", {31'd0, wbb_d}, 32'd1);
    idle(1);
    check_eq("t1_drain2_wb_busy", {31'd0, wbb_d}, 32'd0);

    // ---- 2: back-to-back rs1 dependency on r3 ----
    clear_counters();
    check_eq("t2_clr", {16'd0, cnt_d}, 32'd0);
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd3);
    #1 check_eq("t2_prod_stall", {31'd0, stall_d}, 32'd0);
    tick();
    id_drive(1'b1, 5'd3, 5'd22, 1'b1, 1'b1, 5'd4);
    #1 check_eq("t2_c1_stall", {31'd0, stall_d}, 32'd1);
    check_eq("t2_c1_bubble", {31'd0, bubble_d}, 32'd1);
    check_eq("t2_c1_stall_byp", {31'd0, stall_b}, 32'd1);
    tick();
    check_eq("t2_bubble_ex_busy", {31'd0, exb_d}, 32'd0);
    check_eq("t2_bubble_wb_busy", {31'd0, wbb_d}, 32'd1);
    #1 check_eq("t2_c2_stall", {31'd0, stall_d}, 32'd1);
    check_eq("t2_c2_stall_byp", {31'd0, stall_b}, 32'd0);
    tick();
    check_eq("t2_byp_issued", {31'd0, exb_b}, 32'd1);
    #1 check_eq("t2_c3_stall", {31'd0, stall_d}, 32'd0);
    tick();
    check_eq("t2_issued", {31'd0, exb_d}, 32'd1);
    check_eq("t2_cnt", {16'd0, cnt_d}, 32'd2);
    check_eq("t2_cnt_byp", {16'd0, cnt_b}, 32'd1);
    idle(2);

    // ---- 3: dependency through rt, gated by id_use_rs2; invalid ID ----
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd5);
    tick();
    id_drive(1'b1, 5'd6, 5'd5, 1'b0, 1'b0, 5'd0);
    #1 check_eq("t3_rt_unused", {31'd0, stall_d}, 32'd0);
    id_use_rs2 = 1'b1;
    #1 check_eq("t3_rt_used", {31'd0, stall_d}, 32'd1);
    id_raddr1 = 5'd5;
    id_valid  = 1'b0;
    #1 check_eq("t3_invalid", {31'd0, stall_d}, 32'd0);
    tick();
    check_eq("t3_invalid_ex_busy", {31'd0, exb_d}, 32'd0);
    idle(2);

    // ---- 4: register zero ----
    clear_counters();
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd0);
    tick();
    id_drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
    #1 check_eq("t4_r0_ro_stall", {31'd0, stall_d}, 32'd0);
    check_eq("t4_r0_rw_stall", {31'd0, stall_z}, 32'd1);
    tick();
    #1 check_eq("t4_r0_ro_wb", {31'd0, stall_d}, 32'd0);
    check_eq("t4_r0_rw_wb", {31'd0, stall_z}, 32'd1);
    tick();
    #1 check_eq("t4_r0_rw_done", {31'd0, stall_z}, 32'd0);
    tick();
    check_eq("t4_cnt_ro", {16'd0, cnt_d}, 32'd0);
    check_eq("t4_cnt_rw", {16'd0, cnt_z}, 32'd2);
    idle(2);

    // ---- 5: counter saturation and clear priority ----
    clear_counters();
    for (int i = 0; i < 7; i++) stall_pair();
    check_eq("t5_cnt4_14", {28'd0, cnt_c}, 32'd14);
    check_eq("t5_cnt16_14", {16'd0, cnt_d}, 32'd14);
    stall_pair();
    stall_pair();
    check_eq("t5_cnt4_sat", {28'd0, cnt_c}, 32'd15);
    check_eq("t5_cnt16_18", {16'd0, cnt_d}, 32'd18);
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd7);
    tick();
    id_drive(1'b1, 5'd7, 5'd22, 1'b0, 1'b0, 5'd0);
    #1 check_eq("t5_clr_stall", {31'd0, stall_d}, 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_eq("t5_clr_cnt16", {16'd0, cnt_d}, 32'd0);
    check_eq("t5_clr_cnt4", {28'd0, cnt_c}, 32'd0);
    tick();
    check_eq("t5_after_clr", {16'd0, cnt_d}, 32'd1);
    tick();
    idle(2);

    // ---- 6: asynchronous reset while stalled ----
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd2);
    tick();
    id_drive(1'b1, 5'd20, 5'd21, 1'b0, 1'b1, 5'd3);
    tick();
    id_drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd4);
    #1 check_eq("t6_pre_stall", {31'd0, stall_d}, 32'd1);
    check_eq("t6_pre_ex_busy", {31'd0, exb_d}, 32'd1);
    check_eq("t6_pre_wb_busy", {31'd0, wbb_d}, 32'd1);
    check_eq("t6_pre_cnt", {16'd0, cnt_d}, 32'd1);
    #2 rst = 1'b0;
    #1 check_eq("t6_async_stall", {31'd0, stall_d}, 32'd0);
    check_eq("t6_async_bubble", {31'd0, bubble_d}, 32'd0);
    check_eq("t6_async_ex_busy", {31'd0, exb_d}, 32'd0);
    check_eq("t6_async_wb_busy", {31'd0, wbb_d}, 32'd0);
    check_eq("t6_async_cnt", {16'd0, cnt_d}, 32'd0);
    tick();
    rst = 1'b1;
    #1 check_eq("t6_post_stall", {31'd0, stall_d}, 32'd0);
    tick();
    check_eq("t6_post_issue", {31'd0, exb_d}, 32'd1);
    check_eq("t6_post_cnt", {16'd0, cnt_d}, 32'd0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
